// File: rtl/ramp_gen_if.sv
// ramp_gen_if: control/status bundle between user logic and ramp_gen.
//   start_i, stop_i  : start request (level) and abort request
//   mode_i           : [1] continuous, [0] triangle
//   step_i, lo_i, hi_i : step size and ramp bounds (sampled on accepted start)
//   cnt_o            : registered ramp value
//   time_o           : toggles on every prescaler tick
//   busy_o           : ramp running (UP or DOWN)
//   max_o, min_o     : cnt_o at latched upper / lower bound
//   eos_o            : one-cycle end-of-sequence pulse
interface ramp_gen_if #(
    parameter int Width = 8
);
    logic             start_i;
    logic             stop_i;
    logic [1:0]       mode_i;
    logic [Width-1:0] step_i;
    logic [Width-1:0] lo_i;
    logic [Width-1:0] hi_i;
    logic [Width-1:0] cnt_o;
    logic             time_o;
    logic             busy_o;
    logic             max_o;
    logic             min_o;
    logic             eos_o;

    modport master (
        output start_i, stop_i, mode_i, step_i, lo_i, hi_i,
        input  cnt_o, time_o, busy_o, max_o, min_o, eos_o
    );

    modport slave (
        input  start_i, stop_i, mode_i, step_i, lo_i, hi_i,
        output cnt_o, time_o, busy_o, max_o, min_o, eos_o
    );
endinterface

// File: rtl/ramp_gen.sv
// ramp_gen: parametrised sawtooth/triangle ramp generator with integrated
// prescaler, tick toggle and IDLE/UP/DOWN FSM.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : ramp_gen_if slave (control inputs, ramp and status outputs)
module ramp_gen #(
    parameter int Width    = 8,
    parameter int DivWidth = 26,
    parameter int DivVal   = 10_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    ramp_gen_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;

    localparam logic [DivWidth-1:0] DIV_LAST = DivWidth'(DivVal - 1);

    logic [1:0]          state_q, state_d;
    logic [DivWidth-1:0] div_q, div_d;
    logic                time_q, time_d;
    logic                eos_q, eos_d;
    logic [Width-1:0]    cnt_q, cnt_d;
    logic [Width-1:0]    lo_q, lo_d;
    logic [Width-1:0]    hi_q, hi_d;
    logic [Width-1:0]    step_q, step_d;
    logic [1:0]          mode_q, mode_d;

    logic                tick;
    logic [Width:0]      sum_up;
    logic [Width:0]      diff_dn;
    logic [Width-1:0]    up_sat;
    logic [Width-1:0]    dn_sat;

    assign tick = (div_q == DIV_LAST);

    // One extra bit keeps the sum from wrapping and exposes the borrow of the
    // subtraction. At a turnaround cnt_q sits on the bound, so the same two
    // saturating results also give min(lo+step,hi) and max(hi-step,lo).
    assign sum_up  = {1'b0, cnt_q} + {1'b0, step_q};
    assign diff_dn = {1'b0, cnt_q} - {1'b0, step_q};
    assign up_sat  = (sum_up > {1'b0, hi_q}) ? hi_q : sum_up[Width-1:0];
    assign dn_sat  = (diff_dn[Width] || (diff_dn[Width-1:0] < lo_q)) ? lo_q
                                                                     : diff_dn[Width-1:0];

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        step_d  = step_q;
        mode_d  = mode_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        time_d  = time_q ^ tick;
        eos_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i && (bus.lo_i <= bus.hi_i)) begin
                    mode_d  = bus.mode_i;
                    lo_d    = bus.lo_i;
                    hi_d    = bus.hi_i;
                    step_d  = (bus.step_i == '0) ? Width'(1) : bus.step_i;
                    cnt_d   = bus.lo_i;
                    state_d = S_UP;
                    div_d   = '0;
                end
            end
            S_UP: begin
                if (bus.stop_i) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (cnt_q != hi_q) begin
                        cnt_d = up_sat;
                    end else if (!mode_q[0]) begin
                        if (mode_q[1]) begin
                            cnt_d = lo_q;
                        end else begin
                            state_d = S_IDLE;
                            eos_d   = 1'b1;
                        end
                    end else begin
                        state_d = S_DOWN;
                        cnt_d   = dn_sat;
                    end
                end
            end
            S_DOWN: begin
                if (bus.stop_i) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (cnt_q != lo_q) begin
                        cnt_d = dn_sat;
                    end else if (mode_q[1]) begin
                        state_d = S_UP;
                        cnt_d   = up_sat;
                    end else begin
                        state_d = S_IDLE;
                        eos_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every register update from the
    // values of the previous cycle, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            time_q  <= 1'b0;
            eos_q   <= 1'b0;
            cnt_q   <= '0;
            // NOTE: the latched configuration is reset too, so min_o/max_o are
            // defined out of reset (lo=0, hi=all ones).
            lo_q    <= '0;
            hi_q    <= '1;
            step_q  <= Width'(1);
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            time_q  <= time_d;
            eos_q   <= eos_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.cnt_o  = cnt_q;
    assign bus.time_o = time_q;
    assign bus.busy_o = (state_q != S_IDLE);
    assign bus.max_o  = (cnt_q == hi_q);
    assign bus.min_o  = (cnt_q == lo_q);
    assign bus.eos_o  = eos_q;
endmodule

// File: tb/tb_ramp_gen.sv
// tb_ramp_gen: self-checking bench for ramp_gen (Width=8, DivVal=4).
// Expected ramp values are pushed to a queue when a start is driven and popped
// at each tick edge.
module tb_ramp_gen;
    localparam int W   = 8;
    localparam int DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    ramp_gen_if #(.Width(W)) bus ();

    ramp_gen #(.Width(W), .DivWidth(26), .DivVal(DIV)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, simulation still running");
        $fatal(1, "watchdog");
    end

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [1:0] mode, input int lo, input int hi,
                               input int step);
        bus.mode_i  = mode;
        bus.lo_i    = W'(lo);
        bus.hi_i    = W'(hi);
        bus.step_i  = W'(step);
        bus.start_i = 1'b1;
        step_clk(1);
        bus.start_i = 1'b0;
    endtask

    // Called right after the accepting edge: each queued value must appear at
    // its tick edge and hold for the three cycles before the next one.
    task automatic check_seq(input string name);
        int exp_v;
        int prev;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.cnt_o !== W'(exp_v) || bus.busy_o !== 1'b1) begin
                errors++;
                $display("FAIL %s: cnt=%0d busy=%0b, required cnt=%0d busy=1",
                         name, bus.cnt_o, bus.busy_o, exp_v);
            end
            if (exp_q.size() > 0) begin
                prev = exp_v;
                step_clk(DIV - 1);
                checks++;
                if (bus.cnt_o !== W'(prev) || bus.eos_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_hold: cnt=%0d eos=%0b, required cnt=%0d eos=0",
                             name, bus.cnt_o, bus.eos_o, prev);
                end
                step_clk(1);
            end
        end
    endtask

    // From the last sequence value: eos must appear exactly one tick later.
    task automatic check_eos(input string name, input int last);
        step_clk(DIV - 1);
        checks++;
        if (bus.eos_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_pre_eos: eos=%0b busy=%0b, required eos=0 busy=1",
                     name, bus.eos_o, bus.busy_o);
        end
        step_clk(1);
        checks++;
        if (bus.eos_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.cnt_o !== W'(last)) begin
            errors++;
            $display("FAIL %s_eos: eos=%0b busy=%0b cnt=%0d, required eos=1 busy=0 cnt=%0d",
                     name, bus.eos_o, bus.busy_o, bus.cnt_o, last);
        end
    endtask

    task automatic test_reset();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.mode_i  = 2'b00;
        bus.step_i  = '0;
        bus.lo_i    = '0;
        bus.hi_i    = '0;
        rst_n       = 1'b0;
        #23;
        checks++;
        if (bus.cnt_o !== 8'd0 || bus.busy_o !== 1'b0 || bus.time_o !== 1'b0 ||
            bus.min_o !== 1'b1 || bus.max_o !== 1'b0 || bus.eos_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: cnt=%0d busy=%0b time=%0b min=%0b max=%0b eos=%0b, required 0 0 0 1 0 0",
                     bus.cnt_o, bus.busy_o, bus.time_o, bus.min_o, bus.max_o, bus.eos_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step_clk(DIV - 1);
        checks++;
        if (bus.time_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_time_pre: time=%0b, required 0", bus.time_o);
        end
        step_clk(1);
        checks++;
        if (bus.time_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_time_first: time=%0b, required 1", bus.time_o);
        end
        step_clk(DIV - 1);
        checks++;
        if (bus.time_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_time_hold: time=%0b, required 1", bus.time_o);
        end
        step_clk(1);
        checks++;
        if (bus.time_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_time_second: time=%0b, required 0", bus.time_o);
        end
    endtask

    task automatic test_single_saw();
        drive_start(2'b00, 10, 20, 3);
        exp_q = '{10, 13, 16, 19, 20};
        check_seq("saw");
        check_eos("saw", 20);
        checks++;
        if (bus.max_o !== 1'b1 || bus.min_o !== 1'b0) begin
            errors++;
            $display("FAIL saw_flags: max=%0b min=%0b, required max=1 min=0",
                     bus.max_o, bus.min_o);
        end
        step_clk(1);
        checks++;
        if (bus.eos_o !== 1'b0 || bus.cnt_o !== 8'd20) begin
            errors++;
            $display("FAIL saw_eos_width: eos=%0b cnt=%0d, required eos=0 cnt=20",
                     bus.eos_o, bus.cnt_o);
        end
    endtask

    task automatic test_single_tri();
        drive_start(2'b01, 0, 255, 100);
        exp_q = '{0, 100, 200, 255, 155, 55, 0};
        check_seq("tri");
        check_eos("tri", 0);
        checks++;
        if (bus.min_o !== 1'b1) begin
            errors++;
            $display("FAIL tri_min: min=%0b, required 1", bus.min_o);
        end
        step_clk(2);
    endtask

    task automatic test_abort();
        drive_start(2'b10, 5, 7, 1);
        exp_q = '{5, 6, 7, 5, 6};
        check_seq("cont_saw");
        step_clk(DIV - 1);
        bus.stop_i = 1'b1;
        step_clk(1);
        bus.stop_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.cnt_o !== 8'd6 || bus.eos_o !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%0b cnt=%0d eos=%0b, required busy=0 cnt=6 eos=0",
                     bus.busy_o, bus.cnt_o, bus.eos_o);
        end
        for (int i = 0; i < 2 * DIV; i++) begin
            step_clk(1);
            checks++;
            if (bus.eos_o !== 1'b0 || bus.cnt_o !== 8'd6 || bus.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle: eos=%0b cnt=%0d busy=%0b, required eos=0 cnt=6 busy=0",
                         bus.eos_o, bus.cnt_o, bus.busy_o);
            end
        end
    endtask

    task automatic test_rejects();
        drive_start(2'b00, 9, 3, 1);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.cnt_o !== 8'd6) begin
            errors++;
            $display("FAIL bad_bounds: busy=%0b cnt=%0d, required busy=0 cnt=6",
                     bus.busy_o, bus.cnt_o);
        end
        step_clk(2);
        drive_start(2'b11, 2, 4, 0);
        exp_q = '{2, 3, 4, 3, 2, 3};
        check_seq("step0_tri");
        // Restart attempt with a different config while busy must be ignored.
        bus.mode_i  = 2'b00;
        bus.lo_i    = 8'd100;
        bus.hi_i    = 8'd200;
        bus.step_i  = 8'd50;
        bus.start_i = 1'b1;
        step_clk(DIV - 1);
        bus.start_i = 1'b0;
        checks++;
        if (bus.cnt_o !== 8'd3) begin
            errors++;
            $display("FAIL busy_start_hold: cnt=%0d, required 3", bus.cnt_o);
        end
        step_clk(1);
        checks++;
        if (bus.cnt_o !== 8'd4 || bus.busy_o !== 1'b1 || bus.max_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: cnt=%0d busy=%0b max=%0b, required cnt=4 busy=1 max=1",
                     bus.cnt_o, bus.busy_o, bus.max_o);
        end
        step_clk(DIV);
        checks++;
        if (bus.cnt_o !== 8'd3) begin
            errors++;
            $display("FAIL busy_start_down: cnt=%0d, required 3", bus.cnt_o);
        end
        bus.stop_i = 1'b1;
        step_clk(1);
        bus.stop_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL tri_stop: busy=%0b, required 0", bus.busy_o);
        end
    endtask

    task automatic test_reset_mid_run();
        drive_start(2'b01, 0, 255, 100);
        step_clk(5);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cnt_o !== 8'd0 || bus.busy_o !== 1'b0 || bus.time_o !== 1'b0 ||
            bus.min_o !== 1'b1 || bus.max_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d busy=%0b time=%0b min=%0b max=%0b, required 0 0 0 1 0",
                     bus.cnt_o, bus.busy_o, bus.time_o, bus.min_o, bus.max_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step_clk(1);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%0b cnt=%0d, required busy=0 cnt=0",
                     bus.busy_o, bus.cnt_o);
        end
        drive_start(2'b00, 1, 2, 1);
        exp_q = '{1, 2};
        check_seq("post_reset_saw");
        check_eos("post_reset_saw", 2);
    endtask

    // Called with eos high: a start in that cycle is accepted, here on a
    // degenerate range that holds its single value for one tick.
    task automatic test_back_to_back();
        drive_start(2'b00, 50, 50, 1);
        checks++;
        if (bus.busy_o !== 1'b1 || bus.cnt_o !== 8'd50 || bus.eos_o !== 1'b0 ||
            bus.max_o !== 1'b1 || bus.min_o !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: busy=%0b cnt=%0d eos=%0b max=%0b min=%0b, required 1 50 0 1 1",
                     bus.busy_o, bus.cnt_o, bus.eos_o, bus.max_o, bus.min_o);
        end
        check_eos("degenerate", 50);
        step_clk(1);
    endtask

    initial begin
        test_reset();
        test_single_saw();
        test_single_tri();
        test_abort();
        test_rejects();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
